dmem_responder: RTL

Data-memory responder: the memory end of the CPU data-memory interface (address = ALU result, write data = second register operand, read data feeding the write-back mux). It gives the datapath a multi-cycle, wait-stated RAM model with a req/ready handshake, address decode and error signalling. Instruction fetch is not handled here; this block serves load/store traffic only.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 87 ++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: CPU data-memory handshake bus; DMEM_BYTE_WRITE_EN adds byte enables
interface dmem_if;
    logic req;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic ready;
    logic err;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0] be;
`endif
    modport master (output req, we, addr, wdata,
`ifdef DMEM_BYTE_WRITE_EN
        output be,
`endif
        input rdata, ready, err);
    modport slave (input req, we, addr, wdata,
`ifdef DMEM_BYTE_WRITE_EN
        input be,
`endif
        output rdata, ready, err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word RAM with synchronous byte-masked write and asynchronous read
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    // write only the enabled byte lanes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated load/store RAM responder with decode errors; DMEM_BYTE_WRITE_EN enables byte stores
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0] lat_be, be_in;
    logic [31:0] offset, ram_rdata;
    logic [AW-1:0] index;
    logic valid, ram_we;

`ifdef DMEM_BYTE_WRITE_EN
    assign be_in = bus.be;
`else
    assign be_in = 4'hF;
`endif

    // offset is only meaningful when addr >= BASE_ADDR, so range check never sees a wrapped value
    assign offset = lat_addr - BASE_ADDR;
    assign valid  = lat_addr[1:0] == 2'b00 && lat_addr >= BASE_ADDR && {1'b0, offset} < SPAN;
    assign index  = AW'(offset >> 2);

    // state, wait counter and transaction latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && bus.req) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
                lat_be    <= be_in;
            end
        end
    end

    // next-state: accept in IDLE, count down wait states, single response cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.req) begin
                cnt_n   = CNT_W'(WAIT_CYCLES);
                state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_n   = cnt - CNT_W'(1);
                state_n = (cnt == CNT_W'(1)) ? RESP : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready = state == RESP;
    assign bus.err   = bus.ready && !valid;
    assign bus.rdata = (bus.ready && valid && !lat_we) ? ram_rdata : '0;
    assign ram_we    = bus.ready && valid && lat_we && !reset;

    dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .be    (lat_be),
        .addr  (index),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );
endmodule
